// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Wide adder built from one 4-bit carry-lookahead slice, reused over WIDTH/4 cycles.
// The least-significant nibble is added first, and the slice carry is fed back into the next step.
// Operands arrive on a valid/ready handshake. The result leaves on a valid/ready handshake.
// Optional feature: define NIBBLE_ADDER_SUB_EN to add a sub_i port.
// With sub_i high, the block computes A - B instead of A + B.
// WIDTH must be a multiple of 4 and at least 8.

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
`ifdef NIBBLE_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             busy_o
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    nib_cnt;
    logic             carry_int;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       gen;
    logic [3:0]       prop;
    logic [4:0]       cla_c;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    logic             accept;
    logic             step;
    logic             last_step;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Choose the B value and starting carry to capture.
    // Subtraction is A + ~B + 1, so it reuses the same add slice.
    always_comb begin
        b_load     = b_i;
        carry_load = carry_i;
`ifdef NIBBLE_ADDER_SUB_EN
        if (sub_i) begin
            b_load     = ~b_i;
            carry_load = 1'b1;
        end
`endif
    end

    // Select the operand nibbles for the current step.
    always_comb begin
        a_nib = a_reg[{nib_cnt, 2'b00} +: 4];
        b_nib = b_reg[{nib_cnt, 2'b00} +: 4];
    end

    // 4-bit carry-lookahead slice. Every carry is a flat function of generate, propagate and carry-in.
    always_comb begin
        gen      = a_nib & b_nib;
        prop     = a_nib ^ b_nib;
        cla_c[0] = carry_int;
        cla_c[1] = gen[0]
                 | (prop[0] & carry_int);
        cla_c[2] = gen[1]
                 | (prop[1] & gen[0])
                 | (prop[1] & prop[0] & carry_int);
        cla_c[3] = gen[2]
                 | (prop[2] & gen[1])
                 | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & carry_int);
        cla_c[4] = gen[3]
                 | (prop[3] & gen[2])
                 | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0])
                 | (prop[3] & prop[2] & prop[1] & prop[0] & carry_int);
        slice_sum  = prop ^ cla_c[3:0];
        slice_cout = cla_c[4];
    end

    // Merge this step's slice sum into the partial result.
    // On the last step this gives the full result to commit.
    always_comb begin
        res_next = res_reg;
        res_next[{nib_cnt, 2'b00} +: 4] = slice_sum;
    end

    // State register. Reset returns to IDLE at once, which aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs. The handshake outputs depend only on the current state.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        busy_o     = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                step   = 1'b1;
                if (nib_cnt == LAST_NIB) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, nibble counter, carry feedback and partial result.
    // The operand registers are written only on accept, so the operands stay fixed during RUN.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_int <= 1'b0;
            nib_cnt   <= '0;
            res_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a_i;
            b_reg     <= b_load;
            carry_int <= carry_load;
            nib_cnt   <= '0;
            res_reg   <= '0;
        end else if (step) begin
            res_reg   <= res_next;
            carry_int <= slice_cout;
            if (last_step) begin
                nib_cnt <= '0;
            end else begin
                nib_cnt <= nib_cnt + 1'b1;
            end
        end
    end

    // Committed result. It changes only on the final step, so a partial sum is never visible.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sum_o   <= '0;
            carry_o <= 1'b0;
        end else if (last_step) begin
            sum_o   <= res_next;
            carry_o <= slice_cout;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (WIDTH = 16).
// A cycle-level reference model predicts every handshake output and the committed result.
// The model works from plain arithmetic, and a compare process checks the DUT against it on each falling edge.
// Directed cases with hand-computed expected values also pin the model.
// A randomized phase then applies random operands and random handshakes.

module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk     = 1'b0;
    logic             rstn_i  = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] a_i     = '0;
    logic [WIDTH-1:0] b_i     = '0;
    logic             carry_i = 1'b0;
    logic             sub_i   = 1'b0;

    logic             ready_o;
    logic             valid_o;
    logic             busy_o;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;

    int num_vectors = 0;
    int num_fail    = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .carry_i (carry_i),
`ifdef NIBBLE_ADDER_SUB_EN
        .sub_i   (sub_i),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .carry_o (carry_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model.
    // Phase 0 waits for operands, phase 1 counts down the NIB add steps, and phase 2 presents the result.
    int              m_phase = 0;
    int              m_left  = 0;
    logic [WIDTH:0]  m_pending = '0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic            m_carry = 1'b0;

    function automatic logic [WIDTH:0] refResult(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic cin, input logic sub);
        logic [WIDTH:0] r;
        if (sub)
            r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        else
            r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        return r;
    endfunction

    function automatic logic effSub();
`ifdef NIBBLE_ADDER_SUB_EN
        return sub_i;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            m_phase <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_carry <= 1'b0;
        end else begin
            case (m_phase)
                0: if (valid_i) begin
                    m_pending <= refResult(a_i, b_i, carry_i, effSub());
                    m_left    <= NIB;
                    m_phase   <= 1;
                end
                1: if (m_left == 1) begin
                    m_sum   <= m_pending[WIDTH-1:0];
                    m_carry <= m_pending[WIDTH];
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (ready_i) m_phase <= 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_vectors++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge while out of reset.
    always @(negedge clk) begin
        if (rstn_i) begin
            checkOutput("cmp_ready", 32'(ready_o), 32'(m_phase == 0));
            checkOutput("cmp_busy",  32'(busy_o),  32'(m_phase != 0));
            checkOutput("cmp_valid", 32'(valid_o), 32'(m_phase == 2));
            checkOutput("cmp_sum",   32'(sum_o),   32'(m_sum));
            checkOutput("cmp_carry", 32'(carry_o), 32'(m_carry));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold valid_i until the DUT accepts them.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
        logic accepted;
        accepted = 1'b0;
        a_i = a; b_i = b; carry_i = c; sub_i = s;
        valid_i = 1'b1;
        for (int i = 0; i < 30 && !accepted; i++) begin
            if (ready_o) accepted = 1'b1;
            step();
        end
        valid_i = 1'b0;
        a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
        carry_i = 1'($urandom); sub_i = 1'($urandom);
        checkOutput("accept", 32'(accepted), 32'd1);
    endtask

    // Run one directed operation.
    // Checks the latency, the literal result, the hold behaviour under backpressure and the return to IDLE.
    // With noisy set, extra valid_i pulses carrying other operands arrive during RUN and DONE.
    task automatic runDirected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic s,
                               input logic [WIDTH-1:0] exp_sum, input logic exp_carry,
                               input int hold, input logic noisy);
        int cycles;
        applyStimulus(a, b, c, s);
        cycles = 0;
        while (!valid_o && cycles < 20) begin
            if (noisy) begin
                valid_i = 1'b1; a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
                checkOutput("ready_in_run", 32'(ready_o), 32'd0);
            end
            step();
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(NIB));
        checkOutput("sum_lit",   32'(sum_o),   32'(exp_sum));
        checkOutput("carry_lit", 32'(carry_o), 32'(exp_carry));
        checkOutput("model_sum", 32'(m_sum),   32'(exp_sum));
        ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                valid_i = 1'b1; a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            end
            step();
            checkOutput("hold_valid", 32'(valid_o), 32'd1);
            checkOutput("hold_sum",   32'(sum_o),   32'(exp_sum));
            checkOutput("hold_carry", 32'(carry_o), 32'(exp_carry));
            checkOutput("hold_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checkOutput("release_valid", 32'(valid_o), 32'd0);
        checkOutput("release_ready", 32'(ready_o), 32'd1);
        checkOutput("keep_sum",      32'(sum_o),   32'(exp_sum));
    endtask

    initial begin
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_busy",  32'(busy_o),  32'd0);
        checkOutput("rst_sum",   32'(sum_o),   32'd0);
        checkOutput("rst_carry", 32'(carry_o), 32'd0);
        step();
        rstn_i = 1'b1;
        step();

        $display("[TB] directed cases");
        runDirected(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, 1'b0);
        runDirected(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
        runDirected(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
        runDirected(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 0, 1'b0);
        runDirected(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 5, 1'b1);

        $display("[TB] reset during RUN");
        applyStimulus(16'h8888, 16'h8888, 1'b0, 1'b0);
        step();
        rstn_i = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(valid_o), 32'd0);
        checkOutput("abort_sum",   32'(sum_o),   32'd0);
        checkOutput("abort_carry", 32'(carry_o), 32'd0);
        checkOutput("abort_ready", 32'(ready_o), 32'd1);
        checkOutput("abort_busy",  32'(busy_o),  32'd0);
        step();
        rstn_i = 1'b1;
        step();
        runDirected(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 0, 1'b0);

`ifdef NIBBLE_ADDER_SUB_EN
        $display("[TB] subtract cases");
        runDirected(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0);
        runDirected(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, 1'b0);
`endif

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            valid_i = 1'($urandom);
            ready_i = ($urandom_range(0, 2) != 0);
            a_i     = WIDTH'($urandom);
            b_i     = WIDTH'($urandom);
            carry_i = 1'($urandom);
            sub_i   = 1'($urandom);
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < NIB + 4; i++) step();
        ready_i = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that time-shares one 4-bit carry-lookahead add slice to add WIDTH-bit operands over WIDTH/4 cycles, least-significant nibble first.
- Captures operands on a valid/ready input handshake, steps a nibble counter, and threads the slice carry-out back as the next carry-in.
- Presents the result on a valid/ready output handshake.
- Sits between the datapath register file and any consumer needing a wide add without a wide adder.

Parameters:
- WIDTH, 16: operand/result width; must be a multiple of 4 and >= 8.
- NIB (localparam), WIDTH/4: number of slice steps per operation.

Ports:
- clk_i  input  1  clock, rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- valid_i  input  1  operands present.
- ready_o  output  1  controller can accept operands.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- carry_i  input  1  carry into bit 0.
- valid_o  output  1  result available.
- ready_i  input  1  consumer accepts result.
- sum_o  output  WIDTH  registered sum.
- carry_o  output  1  registered carry out of bit WIDTH-1.
- busy_o  output  1  high in RUN or DONE.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - State = IDLE; nibble counter = 0; internal carry = 0; operand registers = 0.
  - sum_o = 0, carry_o = 0, valid_o = 0, busy_o = 0, ready_o = 1.
- State IDLE:
  - ready_o = 1.
  - On valid_i & ready_o at a clock edge: latch a_i, b_i and carry_i; clear the counter; go to RUN.
- State RUN (exactly NIB cycles):
  - ready_o = 0; busy_o = 1.
  - In cycle k (k = 0..NIB-1), the slice adds A[4k+3:4k] + B[4k+3:4k] + internal carry.
  - The 4-bit slice sum is written to result bits [4k+3:4k].
  - The slice carry-out is registered as the internal carry for cycle k+1.
  - The counter increments each cycle. When the counter = NIB-1: commit the final slice carry to carry_o, update sum_o with the full result, and go to DONE.
  - valid_i is ignored in RUN; the captured operands do not change.
- State DONE:
  - valid_o = 1; sum_o and carry_o are held stable.
  - On ready_i = 1: next state IDLE, valid_o falls on the following edge.
  - If ready_i stays low, hold indefinitely with no change.
  - ready_i is ignored in IDLE and RUN.
- Latency and throughput:
  - Accept edge T. valid_o is high from edge T+NIB onward.
  - Minimum accept-to-accept interval is NIB+2 cycles (ready_i high on the first DONE cycle).
- Width/arithmetic rules:
  - Result is (A + B + carry_i) mod 2^WIDTH; carry_o = bit WIDTH of the true sum.
  - The carry chain must propagate across nibble boundaries, e.g. all-ones + 1 ripples through every step.
- Output holding:
  - sum_o and carry_o update only at the end of RUN.
  - Outside DONE they keep the last committed result (0 after reset).
- Reset mid-operation:
  - Aborts immediately to the reset values.
  - No partial result is ever presented.

Optional Feature:
- Macro NIBBLE_ADDER_SUB_EN.
- Defined:
  - Adds input port sub_i (1 bit), sampled with the operands on accept.
  - When sub_i = 1: the captured B is bitwise inverted and the initial internal carry is forced to 1 (carry_i ignored), so the result is A - B mod 2^WIDTH.
  - carry_o = 1 means no borrow.
  - When sub_i = 0, behaviour is identical to the base block.
- Undefined: no sub_i port; add only.

Test Plan (WIDTH = 16):
- Basic add: accept A = 0x1234, B = 0x4321, carry_i = 0 -> valid_o high 4 cycles after accept; sum_o = 0x5555, carry_o = 0; ready_i = 1 -> IDLE, ready_o = 1 one cycle later.
- Full carry ripple: A = 0xFFFF, B = 0x0001, carry_i = 0 -> sum_o = 0x0000, carry_o = 1.
- Carry-in: A = 0xFFFF, B = 0x0000, carry_i = 1 -> sum_o = 0x0000, carry_o = 1. Also A = 0x0000, B = 0x0000, carry_i = 1 -> sum_o = 0x0001, carry_o = 0.
- Backpressure and busy input:
  - Hold ready_i = 0 for 5 cycles in DONE -> valid_o, sum_o and carry_o stable throughout.
  - valid_i pulsed with other operands during RUN and DONE -> ignored; first result unchanged; ready_o = 0.
- Reset mid-RUN: assert rstn_i low in cycle 2 of RUN for A = 0x8888, B = 0x8888 -> immediately valid_o = 0, sum_o = 0, carry_o = 0, ready_o = 1. Next operation 0x0001 + 0x0002 -> 0x0003.
- With NIBBLE_ADDER_SUB_EN, sub_i = 1:
  - A = 0x0005, B = 0x0007 -> sum_o = 0xFFFE, carry_o = 0.
  - A = 0x0007, B = 0x0005 -> sum_o = 0x0002, carry_o = 1.
